// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit pipelined core: opcodes, instruction
// field positions and the ID/EX pipeline register layout.
package core_pkg;

  localparam int DATA_W  = 8;
  localparam int NREG    = 8;
  localparam int REG_AW  = 3;
  localparam int INSTR_W = 8;

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  // MOV R0,R0 doubles as the NOP encoding.
  localparam logic [INSTR_W-1:0] INSTR_NOP = 8'h00;

  // Instruction field slices: op = [7:6], rd = [5:3], rs = [2:0].
  localparam int OP_HI  = 7;
  localparam int OP_LO  = 6;
  localparam int RD_HI  = 5;
  localparam int RD_LO  = 3;
  localparam int RS_HI  = 2;
  localparam int RS_LO  = 0;
  localparam int TGT_HI = 5;

  typedef struct packed {
    logic [1:0]        op;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;
    logic [REG_AW-1:0] shamt;
    logic              regwrite;
  } idex_t;

  function automatic logic [1:0] instr_op(input logic [INSTR_W-1:0] instr);
    return instr[OP_HI:OP_LO];
  endfunction

  function automatic logic [REG_AW-1:0] instr_rd(input logic [INSTR_W-1:0] instr);
    return instr[RD_HI:RD_LO];
  endfunction

  function automatic logic [REG_AW-1:0] instr_rs(input logic [INSTR_W-1:0] instr);
    return instr[RS_HI:RS_LO];
  endfunction

endpackage

// File: rtl/regfile_8x8.sv
// Architectural register file: two async read ports with write-back
// bypass, one sync write port, reset loads R[i] = i.
module regfile_8x8 #(
  parameter int DATA_W = 8,
  parameter int NREG   = 8,
  parameter int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     rd_addr,
  input  logic [AW-1:0]     rs_addr,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rd_val,
  output logic [DATA_W-1:0] rs_val
);

  logic [NREG-1:0][DATA_W-1:0] mem;

  // Storage: reset wins over a concurrent write-back, which is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) mem[i] <= DATA_W'(i);
    end else if (wb_en) begin
      mem[wb_addr] <= wb_data;
    end
  end

  // Read ports: forward the in-flight write-back so decode never sees stale data.
  always_comb begin
    rd_val = mem[rd_addr];
    rs_val = mem[rs_addr];
    if (wb_en && (wb_addr == rd_addr)) rd_val = wb_data;
    if (wb_en && (wb_addr == rs_addr)) rs_val = wb_data;
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: register read with bypass, combinational jump
// redirect to fetch, and the ID/EX pipeline register.
module id_stage #(
  parameter int DATA_W = 8,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        instr_if_id,
  input  logic              wb_en,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              jump_en,
  output logic [DATA_W-1:0] jump_addr,
  output logic [1:0]        idex_op,
  output logic [2:0]        idex_rd,
  output logic [DATA_W-1:0] idex_rd_val,
  output logic [DATA_W-1:0] idex_rs_val,
  output logic [2:0]        idex_shamt,
  output logic              idex_regwrite
);
  import core_pkg::*;

  logic [1:0]        op;
  logic [2:0]        rd_idx;
  logic [2:0]        rs_idx;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;
  idex_t             dec;
  idex_t             idex_q;

  assign op     = instr_op(instr_if_id);
  assign rd_idx = instr_rd(instr_if_id);
  assign rs_idx = instr_rs(instr_if_id);

  regfile_8x8 #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .AW     (3)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .rd_addr (rd_idx),
    .rs_addr (rs_idx),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .rd_val  (rd_val),
    .rs_val  (rs_val)
  );

  // Jump redirect: pure decode of the IF/ID word, independent of reset.
  always_comb begin
    jump_en   = (op == OP_JMP);
    jump_addr = '0;
    if (jump_en) jump_addr = DATA_W'(instr_if_id[TGT_HI:0]);
  end

  // Decode: JMP carries only its opcode downstream; NOP never writes back.
  always_comb begin
    dec = '0;
    dec.op = op;
    if (op != OP_JMP) begin
      dec.rd       = rd_idx;
      dec.rd_val   = rd_val;
      dec.rs_val   = rs_val;
      dec.shamt    = instr_if_id[RS_HI:RS_LO];
      dec.regwrite = (instr_if_id != INSTR_NOP);
    end
  end

  // ID/EX register: advances every cycle, cleared immediately on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) idex_q <= '0;
    else        idex_q <= dec;
  end

  assign idex_op       = idex_q.op;
  assign idex_rd       = idex_q.rd;
  assign idex_rd_val   = idex_q.rd_val;
  assign idex_rs_val   = idex_q.rs_val;
  assign idex_shamt    = idex_q.shamt;
  assign idex_regwrite = idex_q.regwrite;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: the driver pushes the hand-computed ID/EX
// contents per issued instruction, a monitor pops and compares after each edge.
module tb_id_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] instr_if_id;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       jump_en;
  logic [7:0] jump_addr;
  logic [1:0] idex_op;
  logic [2:0] idex_rd;
  logic [7:0] idex_rd_val;
  logic [7:0] idex_rs_val;
  logic [2:0] idex_shamt;
  logic       idex_regwrite;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      nm;
    logic [1:0] op;
    logic [2:0] rd;
    logic [7:0] rdv;
    logic [7:0] rsv;
    logic [2:0] sh;
    logic       rw;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  id_stage #(.DATA_W(8), .NREG(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .instr_if_id   (instr_if_id),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .jump_en       (jump_en),
    .jump_addr     (jump_addr),
    .idex_op       (idex_op),
    .idex_rd       (idex_rd),
    .idex_rd_val   (idex_rd_val),
    .idex_rs_val   (idex_rs_val),
    .idex_shamt    (idex_shamt),
    .idex_regwrite (idex_regwrite)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_idex(input exp_t e);
    cmp({e.nm, ".op"},  {6'b0, idex_op},       {6'b0, e.op});
    cmp({e.nm, ".rd"},  {5'b0, idex_rd},       {5'b0, e.rd});
    cmp({e.nm, ".rdv"}, idex_rd_val,           e.rdv);
    cmp({e.nm, ".rsv"}, idex_rs_val,           e.rsv);
    cmp({e.nm, ".sh"},  {5'b0, idex_shamt},    {5'b0, e.sh});
    cmp({e.nm, ".rw"},  {7'b0, idex_regwrite}, {7'b0, e.rw});
  endtask

  task automatic check_jump(input string nm, input logic je, input logic [7:0] ja);
    cmp({nm, ".jump_en"},   {7'b0, jump_en}, {7'b0, je});
    cmp({nm, ".jump_addr"}, jump_addr,       ja);
  endtask

  task automatic push(input string nm, input logic [1:0] op, input logic [2:0] rd,
                      input logic [7:0] rdv, input logic [7:0] rsv,
                      input logic [2:0] sh, input logic rw);
    exp_t e;
    e.nm = nm; e.op = op; e.rd = rd; e.rdv = rdv; e.rsv = rsv; e.sh = sh; e.rw = rw;
    sb.push_back(e);
  endtask

  // One issued instruction: drive at negedge, check jump combinationally,
  // queue the ID/EX expectation for the following edge.
  task automatic step(input string nm, input logic [7:0] ins, input logic we,
                      input logic [2:0] wa, input logic [7:0] wd,
                      input logic [1:0] op, input logic [2:0] rd,
                      input logic [7:0] rdv, input logic [7:0] rsv,
                      input logic [2:0] sh, input logic rw,
                      input logic je, input logic [7:0] ja);
    @(negedge clk);
    instr_if_id = ins; wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    check_jump(nm, je, ja);
    push(nm, op, rd, rdv, rsv, sh, rw);
    @(posedge clk);
  endtask

  // Monitor: compare ID/EX outputs shortly after each edge that has an expectation.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check_idex(mon_e);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t z;
    z.nm = "rst_async"; z.op = 0; z.rd = 0; z.rdv = 0; z.rsv = 0; z.sh = 0; z.rw = 0;

    // Reset asserted; jump decode stays live during reset.
    reset = 1'b0; instr_if_id = 8'hE5; wb_en = 1'b0; wb_addr = 3'd0; wb_data = 8'h00;
    #1;
    check_idex(z);
    check_jump("rst_jmp", 1'b1, 8'h25);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      instr_if_id = 8'h00;
      push("rst_hold", 2'd0, 3'd0, 8'h00, 8'h00, 3'd0, 1'b0);
      @(posedge clk);
    end
    @(negedge clk);
    reset = 1'b1;

    //    name        instr  we wa  wd     op  rd  rdv    rsv    sh  rw  je  ja
    step("nop0",     8'h00, 0, 0, 8'h00, 0,  0,  8'h00, 8'h00, 0,  0,  0,  8'h00);
    step("nop1",     8'h00, 0, 0, 8'h00, 0,  0,  8'h00, 8'h00, 0,  0,  0,  8'h00);
    step("add_r1r2", 8'h4A, 0, 0, 8'h00, 1,  1,  8'h01, 8'h02, 2,  1,  0,  8'h00);
    step("jmp_25",   8'hE5, 0, 0, 8'h00, 3,  0,  8'h00, 8'h00, 0,  0,  1,  8'h25);
    step("mov_byp",  8'h13, 1, 3, 8'hAA, 0,  2,  8'h02, 8'hAA, 3,  1,  0,  8'h00);
    step("mov_r3",   8'h13, 0, 0, 8'h00, 0,  2,  8'h02, 8'hAA, 3,  1,  0,  8'h00);
    step("mov_r0r3", 8'h03, 0, 0, 8'h00, 0,  0,  8'h00, 8'hAA, 3,  1,  0,  8'h00);
    step("add_byp",  8'h4A, 1, 1, 8'h10, 1,  1,  8'h10, 8'h02, 2,  1,  0,  8'h00);
    step("add_r1",   8'h4A, 0, 0, 8'h00, 1,  1,  8'h10, 8'h02, 2,  1,  0,  8'h00);
    step("nop_wb0",  8'h00, 1, 0, 8'h55, 0,  0,  8'h55, 8'h55, 0,  0,  0,  8'h00);
    step("mov_r1r0", 8'h08, 0, 0, 8'h00, 0,  1,  8'h10, 8'h55, 0,  1,  0,  8'h00);
    step("jmp_3f",   8'hFF, 0, 0, 8'h00, 3,  0,  8'h00, 8'h00, 0,  0,  1,  8'h3F);
    step("wr_r5",    8'h00, 1, 5, 8'h77, 0,  0,  8'h55, 8'h55, 0,  0,  0,  8'h00);

    // Mid-cycle asynchronous reset with a concurrent write-back to R6.
    #3;
    reset = 1'b0; instr_if_id = 8'h9B; wb_en = 1'b1; wb_addr = 3'd6; wb_data = 8'hFF;
    #1;
    z.nm = "rst_mid";
    check_idex(z);
    check_jump("rst_mid", 1'b0, 8'h00);
    push("rst_mid_edge", 2'd0, 3'd0, 8'h00, 8'h00, 3'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; wb_en = 1'b0;

    step("mov_r0r5", 8'h05, 0, 0, 8'h00, 0,  0,  8'h00, 8'h05, 5,  1,  0,  8'h00);
    step("sll_r3",   8'h9B, 0, 0, 8'h00, 2,  3,  8'h03, 8'h03, 3,  1,  0,  8'h00);
    step("mov_r0r6", 8'h06, 0, 0, 8'h00, 0,  0,  8'h00, 8'h06, 6,  1,  0,  8'h00);
    step("jmp_00",   8'hC0, 0, 0, 8'h00, 3,  0,  8'h00, 8'h00, 0,  0,  1,  8'h00);

    repeat (3) @(posedge clk);
    #2;
    cmp("sb_drained", 8'(sb.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
